count_arbiter: RTL and testbench
================================

// Module: count_arbiter
// PURPOSE
//  Shares one CNT_W-bit up-counter among NUM_REQ requesters using round-robin arbitration.
//  A granted requester gets a timed count from 0 to its own terminal value.
//  The block then pulses that requester's done bit and releases the counter.
//  It sequences loop/delay counts for the datapath controllers, one owner at a time.
// PARAMETERS
//  NUM_REQ  4  number of requesters (>=2)
//  CNT_W    4  counter width; terminal values range 0..2^CNT_W-1
// PORTS
//  clk       in   1               single clock, rising edge
//  reset     in   1               synchronous, active-high
//  req       in   NUM_REQ         per-requester request level
//  term_cnt  in   NUM_REQ*CNT_W   terminal value; requester i at [i*CNT_W +: CNT_W]
//  pause     in   1               freezes the counter while high
//  gnt       out  NUM_REQ         one-hot owner, registered
//  busy      out  1               high in COUNT or DONE
//  cnt_val   out  CNT_W           current count, registered
//  cnt_en    out  1               high in COUNT when pause=0 (count advances this cycle)
//  done      out  NUM_REQ         one-cycle one-hot completion pulse
// BEHAVIOUR
//  Reset
//   - All outputs are 0; state goes to IDLE; round-robin pointer ptr goes to 0.
//   - reset wins over every other input, including mid-COUNT.
//  State IDLE (gnt=0)
//   - If req!=0, grant the first set bit searching ptr, ptr+1, ... modulo NUM_REQ.
//   - On the next edge: gnt=onehot(i), cnt_val=0, latch term_cnt[i] into term_q, go to COUNT.
//   - ptr=(i+1) mod NUM_REQ.
//  State COUNT
//   - pause=1: cnt_val holds and no terminal check is made.
//   - pause=0 and req[i]=0: abort. Next cycle is IDLE with gnt=0, cnt_val=0, no done.
//   - pause=0 and cnt_val!=term_q: cnt_val+1.
//   - pause=0 and cnt_val==term_q: go to DONE. done=onehot(i); gnt, cnt_val cleared.
//   - Abort has priority over the terminal check.
//  State DONE
//   - One cycle; no arbitration happens. Then go to IDLE.
//   - Requester must drop req within this cycle if it needs no further count.
//  Timing (req seen in IDLE at cycle t, term T, no pause)
//   - gnt and cnt_val=0 at t+1; cnt_val=T at t+1+T; done at t+2+T; IDLE at t+3+T.
//   - Count phase is T+1 non-paused cycles; each paused cycle adds one.
//  Arithmetic
//   - term_q is sampled at grant only; later term_cnt changes are ignored.
//   - cnt_val never exceeds term_q, so it never wraps (T=2^CNT_W-1 is legal).
//  Boundaries
//   - T=0 gives exactly one count cycle.
//   - pause in IDLE or DONE has no effect.
//   - Requests arriving during COUNT/DONE wait for IDLE.
//   - Simultaneous requests are resolved by ptr only.
//  Invariants
//   - gnt and done are each one-hot or zero; never both nonzero.
//   - busy = (state!=IDLE).
// TESTING (NUM_REQ=4, CNT_W=4)
//  1. reset=1 two cycles with req=4'b1111 -> gnt=0, done=0, busy=0, cnt_val=0; first grant after reset is 4'b0001.
//  2. req=4'b0100, term[2]=3 -> gnt=4'b0100 next cycle; cnt_val 0,1,2,3; done=4'b0100 one cycle; busy low 2 cycles after cnt_val=3.
//  3. req=4'b1111 held, all terms=1 -> grant order 0001,0010,0100,1000,0001; each done precedes next gnt by 2 cycles.
//  4. term=5; pause high 3 cycles while cnt_val=2 -> cnt_val holds 2, cnt_en=0; done after 9 count cycles instead of 6.
//  5. term=0 -> single cycle with cnt_val=0 then done; term=15 -> cnt_val reaches 15 over 16 cycles, done, no wrap to 0 while gnt set.
//  6. Drop granted req at cnt_val=2 -> next cycle gnt=0, busy=0, no done; reset at cnt_val=7 -> all outputs 0 next cycle, next grant from ptr=0.

Source files
------------

// File: rtl/count_arbiter.sv
// Round-robin sharing of one up-counter: the granted requester counts 0..term,
// then gets a one-cycle done pulse and the counter is released.
module count_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned CNT_W   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] term_cnt,
  input  logic                     pause,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     busy,
  output logic [CNT_W-1:0]         cnt_val,
  output logic                     cnt_en,
  output logic [NUM_REQ-1:0]       done
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t             state, state_n;
  logic [IDX_W-1:0]   ptr, ptr_n;
  logic [IDX_W-1:0]   owner, owner_n;
  logic [IDX_W-1:0]   pick;
  logic               found;
  logic [CNT_W-1:0]   term_q, term_n;
  logic [CNT_W-1:0]   cnt_n;
  logic [NUM_REQ-1:0] gnt_n, done_n;

  // First requester at or after ptr, wrapping around.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!found && req[(32'(ptr) + k) % NUM_REQ]) begin
        found = 1'b1;
        pick  = IDX_W'((32'(ptr) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    owner_n = owner;
    term_n  = term_q;
    cnt_n   = cnt_val;
    gnt_n   = gnt;
    done_n  = '0;
    cnt_en  = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_n = COUNT;
          owner_n = pick;
          ptr_n   = (pick == IDX_W'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
          gnt_n   = NUM_REQ'(1) << pick;
          cnt_n   = '0;
          term_n  = term_cnt[32'(pick)*CNT_W +: CNT_W];
        end
      end
      COUNT: begin
        if (!pause) begin
          cnt_en = 1'b1;
          // Abort outranks the terminal check.
          if (!req[owner]) begin
            state_n = IDLE;
            gnt_n   = '0;
            cnt_n   = '0;
          end else if (cnt_val == term_q) begin
            state_n = DONE;
            done_n  = gnt;
            gnt_n   = '0;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_val + 1'b1;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= '0;
      owner   <= '0;
      term_q  <= '0;
      cnt_val <= '0;
      gnt     <= '0;
      done    <= '0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      owner   <= owner_n;
      term_q  <= term_n;
      cnt_val <= cnt_n;
      gnt     <= gnt_n;
      done    <= done_n;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_count_arbiter.sv
// Directed bench for count_arbiter (NUM_REQ=4, CNT_W=4) with hand-computed expectations.
module tb_count_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] term;
  logic        pause;
  logic [3:0]  gnt;
  logic        busy;
  logic [3:0]  cnt_val;
  logic        cnt_en;
  logic [3:0]  done;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  count_arbiter #(.NUM_REQ(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .req(req), .term_cnt(term), .pause(pause),
    .gnt(gnt), .busy(busy), .cnt_val(cnt_val), .cnt_en(cnt_en), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [3:0] g, input logic b,
                           input logic [3:0] c, input logic [3:0] d);
    check({tag, ".gnt"},  32'(gnt),     32'(g));
    check({tag, ".busy"}, 32'(busy),    32'(b));
    check({tag, ".cnt"},  32'(cnt_val), 32'(c));
    check({tag, ".done"}, 32'(done),    32'(d));
  endtask

  initial begin
    reset = 1'b1;
    req   = 4'b1111;
    term  = 16'h1111;
    pause = 1'b0;

    // 1. reset dominates pending requests
    tick();
    tick();
    check_all("reset", 4'b0000, 1'b0, 4'd0, 4'b0000);
    check("reset.cnt_en", 32'(cnt_en), 32'd0);
    reset = 1'b0;

    // 3. all requesting, all terms 1: rotation starting at requester 0
    for (int g = 0; g < 5; g++) begin
      logic [3:0] eg;
      eg = 4'(1 << (g % 4));
      tick(); check_all("rr.grant", eg, 1'b1, 4'd0, 4'b0000);
      tick(); check_all("rr.cnt1", eg, 1'b1, 4'd1, 4'b0000);
      tick(); check_all("rr.done", 4'b0000, 1'b1, 4'd0, eg);
      tick(); check_all("rr.idle", 4'b0000, 1'b0, 4'd0, 4'b0000);
    end
    req = 4'b0000;

    // 2. single requester 2, term 3 (ptr is 1, search lands on 2)
    term[8 +: 4] = 4'd3;
    req = 4'b0100;
    for (int k = 0; k <= 3; k++) begin
      tick(); check_all("t3.count", 4'b0100, 1'b1, 4'(k), 4'b0000);
    end
    tick(); check_all("t3.done", 4'b0000, 1'b1, 4'd0, 4'b0100);
    pause = 1'b1;
    req = 4'b0000;
    tick(); check_all("t3.idle", 4'b0000, 1'b0, 4'd0, 4'b0000);
    pause = 1'b0;

    // 4. requester 3, term 5, paused three cycles at count 2
    term[12 +: 4] = 4'd5;
    req = 4'b1000;
    tick(); check_all("p.c0", 4'b1000, 1'b1, 4'd0, 4'b0000);
    tick(); check("p.c1", 32'(cnt_val), 32'd1);
    tick(); check("p.c2", 32'(cnt_val), 32'd2);
    pause = 1'b1;
    #1 check("p.en_off", 32'(cnt_en), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick(); check_all("p.hold", 4'b1000, 1'b1, 4'd2, 4'b0000);
    end
    pause = 1'b0;
    #1 check("p.en_on", 32'(cnt_en), 32'd1);
    for (int k = 3; k <= 5; k++) begin
      tick(); check("p.run", 32'(cnt_val), 32'(k));
    end
    tick(); check_all("p.done", 4'b0000, 1'b1, 4'd0, 4'b1000);
    req = 4'b0000;
    tick(); check("p.idle", 32'(busy), 32'd0);

    // 5a. term 0: one count cycle then done (ptr back at 0)
    term[0 +: 4] = 4'd0;
    req = 4'b0001;
    tick(); check_all("t0.count", 4'b0001, 1'b1, 4'd0, 4'b0000);
    tick(); check_all("t0.done", 4'b0000, 1'b1, 4'd0, 4'b0001);
    req = 4'b0000;
    tick();

    // 5b. term 15 on requester 1; term changed after grant must be ignored
    term[4 +: 4] = 4'd15;
    req = 4'b0010;
    tick(); check_all("t15.grant", 4'b0010, 1'b1, 4'd0, 4'b0000);
    term[4 +: 4] = 4'd2;
    for (int k = 1; k <= 15; k++) begin
      tick(); check_all("t15.count", 4'b0010, 1'b1, 4'(k), 4'b0000);
    end
    tick(); check_all("t15.done", 4'b0000, 1'b1, 4'd0, 4'b0010);
    req = 4'b0000;
    tick();

    // 6a. abort: requester 2 drops req at count 2
    term[8 +: 4] = 4'd9;
    req = 4'b0100;
    tick(); check("ab.grant", 32'(gnt), 32'b0100);
    tick();
    tick(); check("ab.c2", 32'(cnt_val), 32'd2);
    req = 4'b0000;
    tick(); check_all("ab.idle", 4'b0000, 1'b0, 4'd0, 4'b0000);

    // 6b. reset mid-count at 7, then arbitration restarts at requester 0
    term[12 +: 4] = 4'd10;
    req = 4'b1000;
    tick(); check("rs.grant", 32'(gnt), 32'b1000);
    for (int k = 0; k < 7; k++) tick();
    check("rs.c7", 32'(cnt_val), 32'd7);
    reset = 1'b1;
    tick(); check_all("rs.clear", 4'b0000, 1'b0, 4'd0, 4'b0000);
    reset = 1'b0;
    req = 4'b1111;
    tick(); check("rs.regrant", 32'(gnt), 32'b0001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
